// File: rtl/m68k_bus_ctrl.sv
// Bus-cycle sequencer between the asynchronous 68000 bus and on-FPGA memory/I/O targets.
// One request per address-strobe assertion, acknowledged by DTACKn or failed with BERRn.
module m68k_bus_ctrl #(
    parameter int         TIMEOUT   = 64,
    parameter logic [2:0] IO_REGION = 3'b111
) (
    input  logic        clk12,
    input  logic        RSTn,
    input  logic        ASn,
    input  logic        UDSn,
    input  logic        LDSn,
    input  logic        R_Wn,
    input  logic [23:1] addr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        DIR,
    output logic        DTACKn,
    output logic        BERRn,
    output logic        mem_req,
    output logic        io_req,
    output logic        t_we,
    output logic [1:0]  t_be,
    output logic [19:0] t_addr,
    output logic [15:0] t_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    input  logic [15:0] io_rdata,
    input  logic        io_ack
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_ACCESS,
        S_DRIVE,
        S_TERM,
        S_ERROR
    } state_t;

    state_t          state;
    logic [1:0]      as_sync, uds_sync, lds_sync, rw_sync;
    logic [1:0]      sync_vld;
    logic            as_s, uds_s, lds_s, rw_s;
    logic            armed;
    logic            io_sel;
    logic [2:0]      region;
    logic [CW-1:0]   cnt;
    logic            sel_ack;
    logic [15:0]     sel_rdata;

    assign as_s      = as_sync[1];
    assign uds_s     = uds_sync[1];
    assign lds_s     = lds_sync[1];
    assign rw_s      = rw_sync[1];
    assign sel_ack   = io_sel ? io_ack : mem_ack;
    assign sel_rdata = io_sel ? io_rdata : mem_rdata;

    // sync_vld marks when the synchronisers hold real samples rather than reset values
    always_ff @(posedge clk12 or negedge RSTn) begin
        if (!RSTn) begin
            as_sync  <= 2'b11;
            uds_sync <= 2'b11;
            lds_sync <= 2'b11;
            rw_sync  <= 2'b11;
            sync_vld <= 2'b00;
        end else begin
            as_sync  <= {as_sync[0], ASn};
            uds_sync <= {uds_sync[0], UDSn};
            lds_sync <= {lds_sync[0], LDSn};
            rw_sync  <= {rw_sync[0], R_Wn};
            sync_vld <= {sync_vld[0], 1'b1};
        end
    end

    // armed stays low after reset until AS is genuinely seen high, so a strobe
    // already in progress when reset released never starts a cycle
    always_ff @(posedge clk12 or negedge RSTn) begin
        if (!RSTn) begin
            state    <= S_IDLE;
            armed    <= 1'b0;
            io_sel   <= 1'b0;
            region   <= 3'b000;
            cnt      <= '0;
            data_out <= 16'h0000;
            DIR      <= 1'b0;
            DTACKn   <= 1'b1;
            BERRn    <= 1'b1;
            mem_req  <= 1'b0;
            io_req   <= 1'b0;
            t_we     <= 1'b0;
            t_be     <= 2'b00;
            t_addr   <= 20'h00000;
            t_wdata  <= 16'h0000;
        end else begin
            mem_req <= 1'b0;
            io_req  <= 1'b0;
            if (sync_vld[1] && as_s) begin
                armed <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (armed && !as_s && (!uds_s || !lds_s)) begin
                        t_addr  <= addr[20:1];
                        region  <= addr[23:21];
                        t_we    <= ~rw_s;
                        t_be    <= ~{uds_s, lds_s};
                        t_wdata <= data_in;
                        state   <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    cnt <= '0;
                    if (region == 3'b000) begin
                        mem_req <= 1'b1;
                        io_sel  <= 1'b0;
                        state   <= S_ACCESS;
                    end else if (region == IO_REGION) begin
                        io_req <= 1'b1;
                        io_sel <= 1'b1;
                        state  <= S_ACCESS;
                    end else begin
                        BERRn <= 1'b0;
                        state <= S_ERROR;
                    end
                end
                // an abandoned strobe beats a same-cycle ack; ack beats the timeout
                S_ACCESS: begin
                    if (as_s) begin
                        state <= S_IDLE;
                    end else if (sel_ack) begin
                        if (!t_we) begin
                            data_out <= sel_rdata;
                        end
                        DIR   <= ~t_we;
                        state <= S_DRIVE;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        BERRn <= 1'b0;
                        state <= S_ERROR;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DRIVE: begin
                    DTACKn <= 1'b0;
                    state  <= S_TERM;
                end
                S_TERM: begin
                    if (as_s) begin
                        DTACKn <= 1'b1;
                        DIR    <= 1'b0;
                        state  <= S_IDLE;
                    end
                end
                S_ERROR: begin
                    DTACKn <= 1'b1;
                    DIR    <= 1'b0;
                    if (as_s) begin
                        BERRn <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_m68k_bus_ctrl.sv
// Directed bench for m68k_bus_ctrl: reads, writes, unmapped access, timeout, abort and reset.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_m68k_bus_ctrl;

    localparam int TIMEOUT = 64;

    logic        clk12 = 1'b0;
    logic        RSTn;
    logic        ASn, UDSn, LDSn, R_Wn;
    logic [23:1] addr;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        DIR, DTACKn, BERRn;
    logic        mem_req, io_req, t_we;
    logic [1:0]  t_be;
    logic [19:0] t_addr;
    logic [15:0] t_wdata;
    logic [15:0] mem_rdata, io_rdata;
    logic        mem_ack, io_ack;

    int total = 0;
    int bad   = 0;

    m68k_bus_ctrl #(.TIMEOUT(TIMEOUT), .IO_REGION(3'b111)) dut (
        .clk12(clk12), .RSTn(RSTn), .ASn(ASn), .UDSn(UDSn), .LDSn(LDSn), .R_Wn(R_Wn),
        .addr(addr), .data_in(data_in), .data_out(data_out), .DIR(DIR),
        .DTACKn(DTACKn), .BERRn(BERRn), .mem_req(mem_req), .io_req(io_req),
        .t_we(t_we), .t_be(t_be), .t_addr(t_addr), .t_wdata(t_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .io_rdata(io_rdata), .io_ack(io_ack)
    );

    always #5 clk12 = ~clk12;

    task automatic start_cycle(input logic [23:0] byte_addr, input logic uds, input logic lds,
                               input logic rw, input logic [15:0] wdata);
        addr    = byte_addr[23:1];
        UDSn    = uds;
        LDSn    = lds;
        R_Wn    = rw;
        data_in = wdata;
        ASn     = 1'b0;
    endtask

    task automatic end_cycle();
        ASn  = 1'b1;
        UDSn = 1'b1;
        LDSn = 1'b1;
        R_Wn = 1'b1;
    endtask

    // n = -1 when neither request appears within the budget
    task automatic wait_req(output int n);
        n = -1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk12);
            if (mem_req || io_req) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_dtack(input logic level, output int n);
        n = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk12);
            if (DTACKn == level) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_berr_high(output int n);
        n = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk12);
            if (BERRn) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        RSTn = 1'b0;
        end_cycle();
        addr = '0; data_in = '0;
        mem_ack = 0; io_ack = 0; mem_rdata = '0; io_rdata = '0;
        repeat (2) @(negedge clk12);
        total++; if (DTACKn !== 1'b1) begin bad++; $display("[TB] FAIL reset_dtack got %b want 1", DTACKn); end
        total++; if (BERRn !== 1'b1) begin bad++; $display("[TB] FAIL reset_berr got %b want 1", BERRn); end
        total++; if (DIR !== 1'b0) begin bad++; $display("[TB] FAIL reset_dir got %b want 0", DIR); end
        total++; if (data_out !== 16'h0) begin bad++; $display("[TB] FAIL reset_data got %h want 0000", data_out); end
        total++;
        if ({mem_req, io_req, t_we, t_be} !== 5'b0 || t_addr !== 20'h0 || t_wdata !== 16'h0) begin
            bad++; $display("[TB] FAIL reset_target got req=%b%b we=%b be=%b addr=%h wd=%h want zeros",
                            mem_req, io_req, t_we, t_be, t_addr, t_wdata);
        end
        RSTn = 1'b1;
        repeat (4) @(negedge clk12);
    endtask

    task automatic test_mem_read();
        int n;
        start_cycle(24'h000010, 1'b0, 1'b0, 1'b1, 16'h0);
        wait_req(n);
        total++; if (n < 0 || mem_req !== 1'b1 || io_req !== 1'b0) begin
            bad++; $display("[TB] FAIL rd_req got mem=%b io=%b want mem=1 io=0", mem_req, io_req); end
        total++; if (t_be !== 2'b11 || t_we !== 1'b0) begin
            bad++; $display("[TB] FAIL rd_be got be=%b we=%b want be=11 we=0", t_be, t_we); end
        total++; if (t_addr !== 20'h00008) begin
            bad++; $display("[TB] FAIL rd_addr got %h want 00008", t_addr); end
        @(negedge clk12);
        total++; if (mem_req !== 1'b0) begin bad++; $display("[TB] FAIL rd_req_width got %b want 0", mem_req); end
        mem_ack = 1'b1; mem_rdata = 16'hBEEF;
        @(negedge clk12);
        mem_ack = 1'b0; mem_rdata = 16'h0;
        total++; if (DTACKn !== 1'b1) begin bad++; $display("[TB] FAIL rd_setup got DTACKn=%b want 1", DTACKn); end
        total++; if (DIR !== 1'b1 || data_out !== 16'hBEEF) begin
            bad++; $display("[TB] FAIL rd_data got DIR=%b data=%h want 1 BEEF", DIR, data_out); end
        @(negedge clk12);
        total++; if (DTACKn !== 1'b0) begin bad++; $display("[TB] FAIL rd_latency got DTACKn=%b want 0", DTACKn); end
        repeat (3) @(negedge clk12);
        total++; if (DTACKn !== 1'b0 || DIR !== 1'b1 || data_out !== 16'hBEEF) begin
            bad++; $display("[TB] FAIL rd_hold got DTACKn=%b DIR=%b data=%h want 0 1 BEEF", DTACKn, DIR, data_out); end
        end_cycle();
        wait_dtack(1'b1, n);
        total++; if (n < 0 || DIR !== 1'b0) begin
            bad++; $display("[TB] FAIL rd_release got DTACKn=%b DIR=%b want 1 0", DTACKn, DIR); end
        repeat (2) @(negedge clk12);
    endtask

    task automatic test_io_write();
        int n;
        logic dir_seen;
        start_cycle(24'hE00003, 1'b1, 1'b0, 1'b0, 16'h0041);
        wait_req(n);
        total++; if (n < 0 || io_req !== 1'b1 || mem_req !== 1'b0) begin
            bad++; $display("[TB] FAIL wr_req got mem=%b io=%b want mem=0 io=1", mem_req, io_req); end
        total++; if (t_we !== 1'b1 || t_be !== 2'b01 || t_wdata !== 16'h0041 || t_addr[7:0] !== 8'h01) begin
            bad++; $display("[TB] FAIL wr_fields got we=%b be=%b wd=%h a=%h want 1 01 0041 01",
                            t_we, t_be, t_wdata, t_addr[7:0]); end
        @(negedge clk12);
        mem_ack = 1'b1;
        @(negedge clk12);
        mem_ack = 1'b0;
        repeat (3) @(negedge clk12);
        total++; if (DTACKn !== 1'b1) begin bad++; $display("[TB] FAIL wr_wrong_ack got DTACKn=%b want 1", DTACKn); end
        io_ack = 1'b1;
        @(negedge clk12);
        io_ack = 1'b0;
        dir_seen = 1'b0;
        n = -1;
        for (int i = 0; i < 6; i++) begin
            if (DIR) dir_seen = 1'b1;
            if (!DTACKn) begin n = i; break; end
            @(negedge clk12);
        end
        total++; if (n < 0) begin bad++; $display("[TB] FAIL wr_dtack got DTACKn=%b want 0", DTACKn); end
        total++; if (dir_seen || DIR !== 1'b0) begin bad++; $display("[TB] FAIL wr_dir got %b want 0", dir_seen | DIR); end
        end_cycle();
        wait_dtack(1'b1, n);
        repeat (2) @(negedge clk12);
    endtask

    task automatic test_unmapped();
        int n;
        int reqs;
        reqs = 0;
        start_cycle(24'h400000, 1'b0, 1'b0, 1'b1, 16'h0);
        n = -1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk12);
            if (mem_req || io_req) reqs++;
            if (!BERRn) begin n = i; break; end
        end
        total++; if (n < 0) begin bad++; $display("[TB] FAIL unm_berr got BERRn=%b want 0", BERRn); end
        repeat (3) begin
            @(negedge clk12);
            if (mem_req || io_req) reqs++;
        end
        total++; if (reqs != 0) begin bad++; $display("[TB] FAIL unm_noreq got %0d reqs want 0", reqs); end
        total++; if (BERRn !== 1'b0 || DTACKn !== 1'b1) begin
            bad++; $display("[TB] FAIL unm_hold got BERRn=%b DTACKn=%b want 0 1", BERRn, DTACKn); end
        end_cycle();
        wait_berr_high(n);
        total++; if (n < 0) begin bad++; $display("[TB] FAIL unm_release got BERRn=%b want 1", BERRn); end
        repeat (2) @(negedge clk12);
    endtask

    task automatic test_timeout();
        int n;
        int berr_at;
        logic dtack_seen;
        berr_at = -1;
        dtack_seen = 1'b0;
        start_cycle(24'h000100, 1'b0, 1'b0, 1'b1, 16'h0);
        wait_req(n);
        total++; if (n < 0) begin bad++; $display("[TB] FAIL to_req got none want mem_req"); end
        for (int k = 1; k <= TIMEOUT + 4; k++) begin
            @(negedge clk12);
            if (!BERRn && berr_at < 0) berr_at = k;
            if (!DTACKn) dtack_seen = 1'b1;
        end
        total++; if (berr_at != TIMEOUT) begin
            bad++; $display("[TB] FAIL to_cycles got %0d want %0d", berr_at, TIMEOUT); end
        mem_ack = 1'b1; mem_rdata = 16'h5555;
        @(negedge clk12);
        mem_ack = 1'b0;
        repeat (3) begin
            @(negedge clk12);
            if (!DTACKn) dtack_seen = 1'b1;
        end
        total++; if (dtack_seen || BERRn !== 1'b0) begin
            bad++; $display("[TB] FAIL to_late_ack got dtack=%b BERRn=%b want 0 0", dtack_seen, BERRn); end
        end_cycle();
        wait_berr_high(n);
        total++; if (n < 0) begin bad++; $display("[TB] FAIL to_release got BERRn=%b want 1", BERRn); end
        repeat (2) @(negedge clk12);
    endtask

    task automatic test_abort();
        int n;
        logic seen;
        seen = 1'b0;
        start_cycle(24'h000020, 1'b0, 1'b0, 1'b1, 16'h0);
        wait_req(n);
        repeat (2) @(negedge clk12);
        end_cycle();
        repeat (4) begin
            @(negedge clk12);
            if (!DTACKn || !BERRn) seen = 1'b1;
        end
        mem_ack = 1'b1; mem_rdata = 16'h7777;
        @(negedge clk12);
        mem_ack = 1'b0;
        repeat (5) begin
            @(negedge clk12);
            if (!DTACKn || !BERRn) seen = 1'b1;
        end
        total++; if (n < 0 || seen) begin
            bad++; $display("[TB] FAIL abort_quiet got req=%0d strobe=%b want req and no strobe", n, seen); end
        start_cycle(24'h000040, 1'b0, 1'b0, 1'b1, 16'h0);
        wait_req(n);
        @(negedge clk12);
        mem_ack = 1'b1; mem_rdata = 16'h1234;
        @(negedge clk12);
        mem_ack = 1'b0;
        wait_dtack(1'b0, n);
        total++; if (n < 0 || data_out !== 16'h1234) begin
            bad++; $display("[TB] FAIL abort_next got DTACKn=%b data=%h want 0 1234", DTACKn, data_out); end
        end_cycle();
        wait_dtack(1'b1, n);
        repeat (2) @(negedge clk12);
    endtask

    task automatic test_stray_ack();
        logic seen;
        seen = 1'b0;
        mem_ack = 1'b1; io_ack = 1'b1;
        repeat (2) @(negedge clk12);
        mem_ack = 1'b0; io_ack = 1'b0;
        repeat (4) begin
            @(negedge clk12);
            if (!DTACKn || DIR || mem_req || io_req) seen = 1'b1;
        end
        total++; if (seen) begin bad++; $display("[TB] FAIL stray_ack got activity=1 want 0"); end
    endtask

    task automatic test_reset_mid_cycle();
        int n;
        int reqs;
        reqs = 0;
        start_cycle(24'h000010, 1'b0, 1'b0, 1'b1, 16'h0);
        wait_req(n);
        @(negedge clk12);
        mem_ack = 1'b1; mem_rdata = 16'hCAFE;
        @(negedge clk12);
        mem_ack = 1'b0;
        wait_dtack(1'b0, n);
        total++; if (n < 0) begin bad++; $display("[TB] FAIL rst_term got DTACKn=%b want 0", DTACKn); end
        #2 RSTn = 1'b0;
        #1;
        total++; if (DTACKn !== 1'b1 || DIR !== 1'b0 || data_out !== 16'h0) begin
            bad++; $display("[TB] FAIL rst_async got DTACKn=%b DIR=%b data=%h want 1 0 0000", DTACKn, DIR, data_out); end
        @(negedge clk12);
        RSTn = 1'b1;
        repeat (8) begin
            @(negedge clk12);
            if (mem_req || io_req) reqs++;
        end
        total++; if (reqs != 0) begin bad++; $display("[TB] FAIL rst_stale got %0d reqs want 0", reqs); end
        end_cycle();
        repeat (3) @(negedge clk12);
        start_cycle(24'h000010, 1'b0, 1'b0, 1'b1, 16'h0);
        wait_req(n);
        total++; if (n < 0 || mem_req !== 1'b1) begin
            bad++; $display("[TB] FAIL rst_fresh got mem_req=%b want 1", mem_req); end
        @(negedge clk12);
        mem_ack = 1'b1; mem_rdata = 16'h0F0F;
        @(negedge clk12);
        mem_ack = 1'b0;
        wait_dtack(1'b0, n);
        end_cycle();
        wait_dtack(1'b1, n);
        repeat (2) @(negedge clk12);
    endtask

    initial begin
        test_reset();
        test_mem_read();
        test_io_write();
        test_unmapped();
        test_timeout();
        test_abort();
        test_stray_ack();
        test_reset_mid_cycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
